// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_sequencer
// Purpose  : Fetches 32-bit instructions from register_memory, decodes them
//            and issues single-register I2C read/write requests. A zero
//            opcode ends the program; errors land in FAULT with a code.
// Ports    : clk, reset (async, active-low)
//            start                       - run request (IDLE/DONE/FAULT only)
//            reg_addr / read_data /
//            error_code                  - instruction memory interface
//            i2c_req_* / i2c_dev_addr /
//            i2c_reg_addr / i2c_wdata    - request to I2C master
//            i2c_req_ready / i2c_done /
//            i2c_ack_err / i2c_rdata     - response from I2C master
//            rd_data / rd_data_valid     - last successful read byte
//            busy / done / fault /
//            fault_code                  - status (1=mem error, 2=bad op,
//                                          3=I2C NACK)
// Revision : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           read_data,
  input  logic [3:0]            error_code,
  output logic                  i2c_req_valid,
  output logic                  i2c_req_rw,
  output logic [7:0]            i2c_dev_addr,
  output logic [7:0]            i2c_reg_addr,
  output logic [7:0]            i2c_wdata,
  input  logic                  i2c_req_ready,
  input  logic                  i2c_done,
  input  logic                  i2c_ack_err,
  input  logic [7:0]            i2c_rdata,
  output logic [7:0]            rd_data,
  output logic                  rd_data_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [3:0]            fault_code
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [7:0]            c_OP_END     = 8'h00;
  localparam logic [7:0]            c_OP_READ    = 8'h01;
  localparam logic [7:0]            c_OP_WRITE   = 8'h02;
  localparam logic [3:0]            c_FC_MEM     = 4'd1;
  localparam logic [3:0]            c_FC_BAD_OP  = 4'd2;
  localparam logic [3:0]            c_FC_NACK    = 4'd3;
  localparam logic [ADDR_WIDTH-1:0] c_PC_ONE     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PC_LAST    = '1;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_next_pc;
  logic                    w_load_req;
  logic                    w_set_fault;
  logic [3:0]              w_fault_val;
  logic                    w_clr_fault;
  logic                    w_rd_capture;

  logic                    r_req_valid;
  logic                    r_req_rw;
  logic [7:0]              r_dev_addr;
  logic [7:0]              r_reg_addr;
  logic [7:0]              r_wdata;
  logic [7:0]              r_rd_data;
  logic                    r_rd_data_valid;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_fault;
  logic [3:0]              r_fault_code;

  logic [7:0]              w_op;
  assign w_op = read_data[31:24];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load_req   = 1'b0;
    w_set_fault  = 1'b0;
    w_fault_val  = 4'd0;
    w_clr_fault  = 1'b0;
    w_rd_capture = 1'b0;
    unique case (r_state)
      IDLE, DONE, FAULT: begin
        if (start) begin
          w_next_state = FETCH;
          w_next_pc    = '0;
          w_clr_fault  = 1'b1;
        end
      end
      FETCH: w_next_state = DECODE;
      DECODE: begin
        // Memory error outranks whatever opcode came back with it.
        if (error_code != 4'd0) begin
          w_next_state = FAULT;
          w_set_fault  = 1'b1;
          w_fault_val  = c_FC_MEM;
        end else if (w_op == c_OP_END) begin
          w_next_state = DONE;
        end else if (w_op == c_OP_READ || w_op == c_OP_WRITE) begin
          w_next_state = ISSUE;
          w_load_req   = 1'b1;
        end else begin
          w_next_state = FAULT;
          w_set_fault  = 1'b1;
          w_fault_val  = c_FC_BAD_OP;
        end
      end
      ISSUE: begin
        if (i2c_req_ready) w_next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i2c_done) begin
          if (i2c_ack_err) begin
            w_next_state = FAULT;
            w_set_fault  = 1'b1;
            w_fault_val  = c_FC_NACK;
          end else begin
            w_rd_capture = r_req_rw;
            // The last address terminates the program instead of wrapping.
            if (r_pc == c_PC_LAST) begin
              w_next_state = DONE;
            end else begin
              w_next_pc    = r_pc + c_PC_ONE;
              w_next_state = FETCH;
            end
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and program counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, derived from the next state so they line up with it
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_valid     <= 1'b0;
      r_req_rw        <= 1'b0;
      r_dev_addr      <= 8'd0;
      r_reg_addr      <= 8'd0;
      r_wdata         <= 8'd0;
      r_rd_data       <= 8'd0;
      r_rd_data_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_fault         <= 1'b0;
      r_fault_code    <= 4'd0;
    end else begin
      r_req_valid     <= (w_next_state == ISSUE);
      r_busy          <= (w_next_state == FETCH) || (w_next_state == DECODE) ||
                         (w_next_state == ISSUE) || (w_next_state == WAIT_DONE);
      r_done          <= (w_next_state == DONE);
      r_fault         <= (w_next_state == FAULT);
      r_rd_data_valid <= w_rd_capture;
      if (w_rd_capture) r_rd_data <= i2c_rdata;
      if (w_load_req) begin
        r_req_rw   <= (w_op == c_OP_READ);
        r_dev_addr <= read_data[23:16];
        r_reg_addr <= read_data[15:8];
        r_wdata    <= (w_op == c_OP_READ) ? 8'd0 : read_data[7:0];
      end
      if (w_clr_fault)      r_fault_code <= 4'd0;
      else if (w_set_fault) r_fault_code <= w_fault_val;
    end
  end

  assign reg_addr      = r_pc;
  assign i2c_req_valid = r_req_valid;
  assign i2c_req_rw    = r_req_rw;
  assign i2c_dev_addr  = r_dev_addr;
  assign i2c_reg_addr  = r_reg_addr;
  assign i2c_wdata     = r_wdata;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_data_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign fault         = r_fault;
  assign fault_code    = r_fault_code;

endmodule
`default_nettype wire
